manta_bus_arbiter: RTL and testbench
====================================

Name: manta_bus_arbiter

Overview:
- Shares the Manta register bus (addr/data/rw/valid daisy chain of cores) between two masters:
  - the UART host bridge (bridge_rx → cores → bridge_tx);
  - an on-chip poll engine that reads/writes core registers autonomously.
- Issues one transaction at a time, tracks the owner, and routes the chain's return beat back to that owner.
- A timeout recovers from unmapped addresses.
- Sits between bridge_rx/bridge_tx and the first/last core in the chain.

Parameters:
- TIMEOUT, 64: cycles WAIT may last without a return beat before a synthetic response is generated (≥2).
- TIMEOUT_DATA, 16'hDEAD: data value returned on a timed-out transaction.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- h_addr_i  in  16  host request address (from bridge_rx)
- h_data_i  in  16  host request write data
- h_rw_i  in  1  host request: 1=write, 0=read
- h_valid_i  in  1  host request strobe (one cycle; no backpressure possible)
- h_data_o  out  16  host response data (to bridge_tx)
- h_rw_o  out  1  host response rw
- h_valid_o  out  1  host response strobe
- p_addr_i  in  16  poll request address
- p_data_i  in  16  poll request write data
- p_rw_i  in  1  poll request rw
- p_valid_i  in  1  poll request valid (held until accepted)
- p_ready_o  out  1  poll request accepted when p_valid_i & p_ready_o
- p_rdata_o  out  16  poll response data
- p_rvalid_o  out  1  poll response strobe
- bus_addr_o  out  16  to first core, addr_i
- bus_data_o  out  16  to first core, data_i
- bus_rw_o  out  1  to first core, rw_i
- bus_valid_o  out  1  to first core, valid_i
- ret_data_i  in  16  from last core, data_o
- ret_rw_i  in  1  from last core, rw_o
- ret_valid_i  in  1  from last core, valid_o
- timeout_o  out  1  one-cycle pulse on synthetic timeout response
- drop_count_o  out  8  saturating count of host requests dropped on FIFO overflow

Behaviour:
- Reset:
  - All outputs 0 except p_ready_o, which follows its combinational definition.
  - FIFO empty, state IDLE, counters 0, owner cleared.
- Host FIFO:
  - 2 entries of {addr, data, rw}; enqueue on h_valid_i.
  - If full and no dequeue in the same cycle, the request is dropped and drop_count_o increments, saturating at 255.
  - Enqueue and dequeue in the same cycle is allowed while full; no drop.
- p_ready_o (combinational) = (state==IDLE) & FIFO empty & !h_valid_i. Host always wins simultaneous requests.
- FSM states: IDLE, WAIT.
  - IDLE, FIFO non-empty:
    - Pop the head and drive bus_* registered, with bus_valid_o=1 for exactly one cycle.
    - owner=HOST; go to WAIT; timeout counter cleared.
  - IDLE, FIFO empty, p_valid_i & p_ready_o:
    - Same issue sequence with the poll fields; owner=POLL.
  - WAIT, ret_valid_i:
    - Next cycle, the owner's response strobe is high for one cycle.
    - HOST: h_data_o=ret_data_i, h_rw_o=ret_rw_i.
    - POLL: p_rdata_o=ret_data_i.
    - State returns to IDLE.
  - WAIT, counter reaches TIMEOUT-1 with no ret_valid_i:
    - Synthetic response to the owner: data=TIMEOUT_DATA, rw=the issued rw.
    - timeout_o=1 for one cycle; state returns to IDLE.
  - ret_valid_i and timeout in the same cycle: ret_valid_i wins and timeout_o stays 0.
- ret_valid_i outside WAIT (stray or late beat after a timeout/reset) is ignored.
- Latency:
  - Host: h_valid_i at cycle t with arbiter idle and FIFO empty gives bus_valid_o at t+2.
  - Poll: handshake at t gives bus_valid_o at t+1.
  - Return: ret_valid_i at t gives the response strobe at t+1.
  - Earliest next issue: the cycle the response strobe is high.
- bus_addr_o, bus_data_o and bus_rw_o are forced to 0 when bus_valid_o=0, matching the idle convention of the cores.
- Write transactions still return a beat and generate a response strobe; bridge_tx ignores writes by rw.
- Reset mid-WAIT: the transaction is abandoned, no response is emitted, and FIFO contents are lost.

Test Plan:
- Host read: h_addr_i=0x0001, rw=0 at t0; model core returns 0xBEEF 1 cycle after bus_valid_o → bus_valid_o at t0+2 with addr 0x0001; h_valid_o at t0+4, h_data_o=0xBEEF; p_rvalid_o stays 0.
- Conflict: h_valid_i and p_valid_i both high at t0 → p_ready_o=0; host issued first; poll accepted on the cycle the host response strobe rises; poll transaction issued next cycle.
- Overflow: 4 host requests on consecutive cycles while WAIT is stalled by a core holding the return → first issued, 2 queued, 4th dropped; drop_count_o=1; after 300 drops the counter holds at 255.
- Timeout: poll read of unmapped 0x7FFF with no return beat → p_rvalid_o exactly TIMEOUT+1 cycles after bus_valid_o; p_rdata_o=0xDEAD; timeout_o pulses once.
- Race: ret_valid_i asserted on the same cycle as the final timeout cycle → real data is delivered and timeout_o=0; a stray ret_valid_i in IDLE produces no response.
- Reset mid-WAIT: rst pulsed during a host transaction → all outputs 0, no h_valid_o; late ret_valid_i ignored; next host read completes normally.

Source files
------------

// File: rtl/manta_bus_arbiter.sv
// Manta register bus arbiter: shares the core daisy chain between the UART
// host bridge and the on-chip poll engine, one transaction at a time.
module manta_bus_arbiter #(
   parameter int unsigned TIMEOUT      = 64,
   parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] h_addr_i,
   input  logic [15:0] h_data_i,
   input  logic        h_rw_i,
   input  logic        h_valid_i,
   output logic [15:0] h_data_o,
   output logic        h_rw_o,
   output logic        h_valid_o,
   input  logic [15:0] p_addr_i,
   input  logic [15:0] p_data_i,
   input  logic        p_rw_i,
   input  logic        p_valid_i,
   output logic        p_ready_o,
   output logic [15:0] p_rdata_o,
   output logic        p_rvalid_o,
   output logic [15:0] bus_addr_o,
   output logic [15:0] bus_data_o,
   output logic        bus_rw_o,
   output logic        bus_valid_o,
   input  logic [15:0] ret_data_i,
   input  logic        ret_rw_i,
   input  logic        ret_valid_i,
   output logic        timeout_o,
   output logic [7:0]  drop_count_o
);

   localparam int unsigned CW    = $clog2(TIMEOUT);
   localparam int unsigned DEPTH = 2;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
      logic        rw;
   } req_t;

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic {OWN_HOST, OWN_POLL} owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   req_t        fifo_q [DEPTH];
   req_t        fifo_d [DEPTH];
   logic [1:0]  fcnt_q, fcnt_d;
   logic [7:0]  drop_q, drop_d;
   logic        issued_rw_q, issued_rw_d;
   logic [CW-1:0] tcnt_q, tcnt_d;
   req_t        bus_q, bus_d;
   logic        bus_valid_q, bus_valid_d;
   logic [15:0] h_data_q, h_data_d;
   logic        h_rw_q, h_rw_d;
   logic        h_valid_q, h_valid_d;
   logic [15:0] p_rdata_q, p_rdata_d;
   logic        p_rvalid_q, p_rvalid_d;
   logic        timeout_q, timeout_d;

   logic        p_ready;
   logic        deq;
   logic        drop;
   logic        resp_fire;
   logic [15:0] resp_data;
   logic        resp_rw;

   // Poll engine may only start when nothing from the host is pending or arriving
   assign p_ready = (state_q == IDLE) && (fcnt_q == 2'd0) && !h_valid_i;

   // Next-state: issue, wait/timeout, response routing and host FIFO
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      fifo_d      = fifo_q;
      fcnt_d      = fcnt_q;
      drop_d      = drop_q;
      issued_rw_d = issued_rw_q;
      tcnt_d      = tcnt_q;
      bus_d       = '0;
      bus_valid_d = 1'b0;
      h_data_d    = h_data_q;
      h_rw_d      = h_rw_q;
      h_valid_d   = 1'b0;
      p_rdata_d   = p_rdata_q;
      p_rvalid_d  = 1'b0;
      timeout_d   = 1'b0;
      deq         = 1'b0;
      resp_fire   = 1'b0;
      resp_data   = '0;
      resp_rw     = 1'b0;

      case (state_q)
         IDLE: begin
            if (fcnt_q != 2'd0) begin
               deq         = 1'b1;
               bus_d       = fifo_q[0];
               bus_valid_d = 1'b1;
               owner_d     = OWN_HOST;
               issued_rw_d = fifo_q[0].rw;
               tcnt_d      = '0;
               state_d     = WAIT;
            end else if (p_valid_i && p_ready) begin
               bus_d       = '{addr: p_addr_i, data: p_data_i, rw: p_rw_i};
               bus_valid_d = 1'b1;
               owner_d     = OWN_POLL;
               issued_rw_d = p_rw_i;
               tcnt_d      = '0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            // The counter only starts once the beat has left, so a real
            // return landing on the last counted cycle still beats the timeout
            if (ret_valid_i) begin
               resp_fire = 1'b1;
               resp_data = ret_data_i;
               resp_rw   = ret_rw_i;
            end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
               resp_fire = 1'b1;
               resp_data = TIMEOUT_DATA;
               resp_rw   = issued_rw_q;
               timeout_d = 1'b1;
            end else if (!bus_valid_q) begin
               tcnt_d = tcnt_q + CW'(1);
            end
            if (resp_fire) begin
               state_d = IDLE;
               if (owner_q == OWN_HOST) begin
                  h_valid_d = 1'b1;
                  h_data_d  = resp_data;
                  h_rw_d    = resp_rw;
               end else begin
                  p_rvalid_d = 1'b1;
                  p_rdata_d  = resp_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Host FIFO: head is always entry 0; a pop shifts entry 1 down
      drop = h_valid_i && (fcnt_q == 2'(DEPTH)) && !deq;
      if (deq) begin
         fifo_d[0] = fifo_q[1];
         fcnt_d    = fcnt_q - 2'd1;
      end
      if (h_valid_i && !drop) begin
         fifo_d[fcnt_d[0]] = '{addr: h_addr_i, data: h_data_i, rw: h_rw_i};
         fcnt_d            = fcnt_d + 2'd1;
      end
      if (drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_HOST;
         fifo_q      <= '{default: '0};
         fcnt_q      <= '0;
         drop_q      <= '0;
         issued_rw_q <= 1'b0;
         tcnt_q      <= '0;
         bus_q       <= '0;
         bus_valid_q <= 1'b0;
         h_data_q    <= '0;
         h_rw_q      <= 1'b0;
         h_valid_q   <= 1'b0;
         p_rdata_q   <= '0;
         p_rvalid_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         fifo_q      <= fifo_d;
         fcnt_q      <= fcnt_d;
         drop_q      <= drop_d;
         issued_rw_q <= issued_rw_d;
         tcnt_q      <= tcnt_d;
         bus_q       <= bus_d;
         bus_valid_q <= bus_valid_d;
         h_data_q    <= h_data_d;
         h_rw_q      <= h_rw_d;
         h_valid_q   <= h_valid_d;
         p_rdata_q   <= p_rdata_d;
         p_rvalid_q  <= p_rvalid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign p_ready_o    = p_ready;
   assign bus_addr_o   = bus_q.addr;
   assign bus_data_o   = bus_q.data;
   assign bus_rw_o     = bus_q.rw;
   assign bus_valid_o  = bus_valid_q;
   assign h_data_o     = h_data_q;
   assign h_rw_o       = h_rw_q;
   assign h_valid_o    = h_valid_q;
   assign p_rdata_o    = p_rdata_q;
   assign p_rvalid_o   = p_rvalid_q;
   assign timeout_o    = timeout_q;
   assign drop_count_o = drop_q;

endmodule

// File: tb/tb_manta_bus_arbiter.sv
// Scoreboard bench for manta_bus_arbiter with a behavioural core chain.
module tb_manta_bus_arbiter;

   localparam int unsigned TO = 8;
   localparam logic [15:0] TD = 16'hDEAD;

   logic        clk = 1'b0, rst = 1'b1;
   logic [15:0] h_addr = '0, h_data = '0;
   logic        h_rw = 1'b0, h_valid = 1'b0;
   logic [15:0] p_addr = '0, p_data = '0;
   logic        p_rw = 1'b0, p_valid = 1'b0;
   logic [15:0] ret_data = '0;
   logic        ret_rw = 1'b0, ret_valid = 1'b0;

   logic [15:0] h_data_o, p_rdata_o, bus_addr_o, bus_data_o;
   logic        h_rw_o, h_valid_o, p_ready_o, p_rvalid_o, bus_rw_o, bus_valid_o, timeout_o;
   logic [7:0]  drop_count_o;

   manta_bus_arbiter #(.TIMEOUT(TO), .TIMEOUT_DATA(TD)) dut (
      .clk(clk), .rst(rst),
      .h_addr_i(h_addr), .h_data_i(h_data), .h_rw_i(h_rw), .h_valid_i(h_valid),
      .h_data_o(h_data_o), .h_rw_o(h_rw_o), .h_valid_o(h_valid_o),
      .p_addr_i(p_addr), .p_data_i(p_data), .p_rw_i(p_rw), .p_valid_i(p_valid),
      .p_ready_o(p_ready_o), .p_rdata_o(p_rdata_o), .p_rvalid_o(p_rvalid_o),
      .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o),
      .bus_valid_o(bus_valid_o),
      .ret_data_i(ret_data), .ret_rw_i(ret_rw), .ret_valid_i(ret_valid),
      .timeout_o(timeout_o), .drop_count_o(drop_count_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [15:0] addr; logic [15:0] data; logic rw; } req_t;
   typedef struct { logic [15:0] data; logic rw; logic to; } rsp_t;

   rsp_t exp_h[$];
   rsp_t exp_p[$];
   req_t poll_q[$];

   int checks = 0, failures = 0;
   int force_lat = -1;
   int stray_pend = 0;
   int last_beat_cyc = -1, last_h_cyc = -1, last_p_cyc = -1, p_acc_cyc = -1;
   logic [15:0] last_beat_addr = '0;
   int to_cnt = 0, flood_rsp = 0;
   bit flood = 1'b0;
   logic [15:0] flood_addr = 16'h0010;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string why);
      checks++;
      failures++;
      $display("FAIL %s %s (cycle %0d)", name, why, cyc);
   endtask

   // Core chain behaviour: reads return a fixed function of the address,
   // writes echo the data; addresses from 0x7000 up are unmapped.
   function automatic logic [15:0] core_rd(input logic [15:0] a);
      return (a == 16'h0001) ? 16'hBEEF : (a ^ 16'hA5C3);
   endfunction

   function automatic logic mapped(input logic [15:0] a);
      return a < 16'h7000;
   endfunction

   // Transaction-level reference: what the owner must eventually receive
   function automatic rsp_t model(input req_t r);
      rsp_t s;
      s.rw = r.rw;
      if (!mapped(r.addr) || force_lat > int'(TO)) begin
         s.data = TD;
         s.to   = 1'b1;
      end else begin
         s.data = r.rw ? r.data : core_rd(r.addr);
         s.to   = 1'b0;
      end
      return s;
   endfunction

   // Core chain model
   initial begin
      req_t r;
      int   lat;
      forever begin
         @(negedge clk);
         if (bus_valid_o) begin
            r = '{bus_addr_o, bus_data_o, bus_rw_o};
            last_beat_cyc  = cyc;
            last_beat_addr = bus_addr_o;
            if (mapped(r.addr)) begin
               lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, TO));
               repeat (lat) @(negedge clk);
               ret_data  = r.rw ? r.data : core_rd(r.addr);
               ret_rw    = r.rw;
               ret_valid = 1'b1;
               @(negedge clk);
               ret_valid = 1'b0;
               ret_data  = '0;
               ret_rw    = 1'b0;
            end
         end else begin
            chk("bus_idle_zero", {bus_rw_o, bus_addr_o, bus_data_o}, 64'd0);
            if (stray_pend > 0) begin
               ret_data  = 16'h1234;
               ret_valid = 1'b1;
               @(negedge clk);
               ret_valid = 1'b0;
               ret_data  = '0;
               stray_pend--;
            end
         end
      end
   end

   // Response monitor / scoreboard
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (timeout_o) to_cnt++;
         chk("single_strobe", h_valid_o & p_rvalid_o, 64'd0);
         chk("timeout_has_strobe", timeout_o & ~h_valid_o & ~p_rvalid_o, 64'd0);
         if (h_valid_o) begin
            last_h_cyc = cyc;
            if (flood) begin
               flood_rsp++;
               chk("flood_rsp", {h_data_o, h_rw_o, timeout_o}, {core_rd(flood_addr), 1'b0, 1'b0});
            end else if (exp_h.size() == 0) begin
               fail("h_unexpected", $sformatf("actual=strobe data=%0h required=none", h_data_o));
            end else begin
               e = exp_h.pop_front();
               chk("h_rsp", {h_data_o, h_rw_o, timeout_o}, {e.data, e.rw, e.to});
            end
         end
         if (p_rvalid_o) begin
            last_p_cyc = cyc;
            if (exp_p.size() == 0) begin
               fail("p_unexpected", $sformatf("actual=strobe data=%0h required=none", p_rdata_o));
            end else begin
               e = exp_p.pop_front();
               chk("p_rsp", {p_rdata_o, timeout_o}, {e.data, e.to});
            end
         end
      end
   end

   // Poll engine driver: holds valid until accepted
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!p_valid && poll_q.size() > 0) begin
            p_addr  = poll_q[0].addr;
            p_data  = poll_q[0].data;
            p_rw    = poll_q[0].rw;
            p_valid = 1'b1;
         end
         if (p_valid) begin
            #1;
            if (p_ready_o) begin
               p_acc_cyc = cyc;
               exp_p.push_back(model(poll_q.pop_front()));
               @(negedge clk);
               p_valid = 1'b0;
               p_addr  = '0;
               p_data  = '0;
               p_rw    = 1'b0;
            end
         end
      end
   end

   task automatic host_drive(input logic [15:0] a, input logic [15:0] d, input logic r, input bit push);
      h_addr  = a;
      h_data  = d;
      h_rw    = r;
      h_valid = 1'b1;
      if (push) exp_h.push_back(model('{a, d, r}));
   endtask

   task automatic host_clear();
      h_valid = 1'b0;
      h_addr  = '0;
      h_data  = '0;
      h_rw    = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((exp_h.size() != 0 || exp_p.size() != 0 || poll_q.size() != 0 || p_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) fail(name, "response wait expired");
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_resp"}, {h_data_o, h_rw_o, h_valid_o, p_rdata_o, p_rvalid_o, timeout_o, drop_count_o}, 64'd0);
      chk({name, "_bus"}, {bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o}, 64'd0);
      chk({name, "_p_ready"}, p_ready_o, 64'd1);
   endtask

   initial begin
      int t0, b0, to0, n;
      logic [15:0] a;

      // Reset state
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Host read latency
      force_lat = 1;
      t0 = cyc;
      host_drive(16'h0001, 16'h0000, 1'b0, 1'b1);
      @(negedge clk);
      host_clear();
      drain(100, "host_read_wait");
      chk("host_beat_cycle", last_beat_cyc, t0 + 2);
      chk("host_beat_addr", last_beat_addr, 16'h0001);
      chk("host_rsp_cycle", last_h_cyc, t0 + 4);

      // Host/poll conflict
      force_lat = 2;
      poll_q.push_back('{16'h0020, 16'h0000, 1'b0});
      host_drive(16'h0030, 16'h5555, 1'b1, 1'b1);
      #3 chk("conflict_p_ready", p_ready_o, 64'd0);
      @(negedge clk);
      host_clear();
      drain(100, "conflict_wait");
      chk("poll_accept_on_h_rsp", p_acc_cyc, last_h_cyc);
      chk("poll_beat_after_accept", last_beat_cyc, p_acc_cyc + 1);
      chk("poll_beat_addr", last_beat_addr, 16'h0020);

      // FIFO overflow while WAIT is stalled
      force_lat = TO;
      for (int i = 0; i < 4; i++) begin
         host_drive(16'h0100 + 16'(i), 16'h0000, 1'b0, i < 3);
         @(negedge clk);
      end
      host_clear();
      chk("drop_after_overflow", drop_count_o, 64'd1);
      drain(200, "overflow_wait");
      chk("drop_held", drop_count_o, 64'd1);

      // Poll timeout on unmapped address
      force_lat = -1;
      to0 = to_cnt;
      poll_q.push_back('{16'h7FFF, 16'h0000, 1'b0});
      drain(100, "timeout_wait");
      chk("timeout_latency", last_p_cyc - last_beat_cyc, TO + 1);
      chk("timeout_pulses", to_cnt - to0, 64'd1);

      // Return beat on the final timeout cycle wins
      force_lat = TO;
      to0 = to_cnt;
      host_drive(16'h0042, 16'h0000, 1'b0, 1'b1);
      @(negedge clk);
      host_clear();
      drain(100, "race_wait");
      chk("race_latency", last_h_cyc - last_beat_cyc, TO + 1);
      chk("race_no_timeout", to_cnt - to0, 64'd0);

      // Stray beat in IDLE, then a late beat after a timeout
      stray_pend = 1;
      repeat (6) @(negedge clk);
      force_lat = TO + 3;
      to0 = to_cnt;
      poll_q.push_back('{16'h0050, 16'h0000, 1'b0});
      drain(100, "late_wait");
      repeat (8) @(negedge clk);
      chk("late_timeout_pulses", to_cnt - to0, 64'd1);

      // Reset in the middle of a host transaction
      force_lat = 6;
      b0 = last_beat_cyc;
      host_drive(16'h0060, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      host_clear();
      n = 0;
      while (last_beat_cyc == b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) fail("midwait_beat", "beat wait expired");
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_outputs("midwait_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      force_lat = 1;
      t0 = cyc;
      host_drive(16'h0001, 16'h0000, 1'b0, 1'b1);
      @(negedge clk);
      host_clear();
      drain(100, "post_reset_wait");
      chk("post_reset_rsp_cycle", last_h_cyc, t0 + 4);

      // Randomized mix of host and poll traffic
      force_lat = -1;
      for (int i = 0; i < 80; i++) begin
         a = ($urandom_range(0, 7) == 0) ? (16'h7000 | 16'($urandom)) : (16'($urandom) & 16'h0FFF);
         if ($urandom_range(0, 1) == 1 && exp_h.size() < 2) begin
            host_drive(a, 16'($urandom), 1'($urandom), 1'b1);
            @(negedge clk);
            host_clear();
         end
         if ($urandom_range(0, 1) == 1 && poll_q.size() == 0 && !p_valid) begin
            poll_q.push_back('{a ^ 16'h0155, 16'($urandom), 1'($urandom)});
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain(4000, "random_wait");
      chk("random_no_drop", drop_count_o, 64'd0);

      // Continuous host flood saturates the drop counter
      force_lat = TO;
      flood = 1'b1;
      for (int i = 0; i < 400; i++) begin
         host_drive(flood_addr, 16'h0000, 1'b0, 1'b0);
         @(negedge clk);
      end
      host_clear();
      repeat (60) @(negedge clk);
      flood = 1'b0;
      chk("drop_saturated", drop_count_o, 64'd255);
      chk("flood_served", flood_rsp > 0, 64'd1);
      chk("final_queues_empty", exp_h.size() + exp_p.size(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
